data_mem_access_ctrl: RTL
=========================

Name: data_mem_access_ctrl

Overview:
Sequences every load/store issued by the EX stage onto the data SRAM through a split req/addr_ok/data_ok handshake. Generates the byte-lane enables and the replicated store data. Raises a stall request while an access is in flight. Returns a size- and sign-adjusted load result to the MEM stage. Sits between the EX/MEM boundary and the data SRAM port, and feeds the pipeline stall controller.

Parameters:
ADDR_W, 32, data address width
DATA_W, 32, SRAM data width (fixed at 32; byte-lane logic is sized for 4 lanes)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  EX presents a memory op this cycle
req_we  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word; 11 is illegal and treated as word
req_unsigned  input  1  zero-extend load (LBU/LHU)
req_addr  input  ADDR_W  effective address
req_wdata  input  32  store source register value
flush  input  1  pipeline flush; kills the current op
pipe_hold  input  1  MEM stage held by a downstream stall
sram_req  output  1  request to SRAM
sram_wr  output  1  write request
sram_wstrb  output  4  byte lanes
sram_addr  output  ADDR_W  word-aligned address (low 2 bits zero)
sram_wdata  output  32  lane-replicated store data
sram_addr_ok  input  1  request accepted
sram_data_ok  input  1  read data valid / write complete
sram_rdata  input  32  read data
stallreq  output  1  stall request to the pipeline controller
resp_valid  output  1  load result/store completion held for MEM
resp_rdata  output  32  extended load result (0 for stores)
err_adel  output  1  misaligned load, 1-cycle pulse
err_ades  output  1  misaligned store, 1-cycle pulse

Behaviour:
- Reset: state=IDLE. All outputs 0. Captured request registers cleared.
- Misalignment check:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - A misaligned op pulses err_adel or err_ades in the cycle req_valid is seen in IDLE.
  - No SRAM request is made. stallreq=0. State stays IDLE.
- Lane generation:
  - byte: wstrb = 1 shifted left by addr[1:0]; wdata = wdata[7:0] replicated to 4 lanes.
  - half: wstrb = 0011 or 1100 by addr[1]; wdata = wdata[15:0] replicated to 2 lanes.
  - word: wstrb = 1111.
  - Loads: wstrb = 0000 and sram_wr = 0.
- States: IDLE, REQ, WAIT, DONE, CANCEL.
- IDLE:
  - On an aligned req_valid with flush=0, capture the request and drive sram_req=1 combinationally in the same cycle.
  - If sram_addr_ok=1 that cycle, go to WAIT; otherwise go to REQ.
  - stallreq=1 combinationally from that cycle.
- REQ:
  - Hold sram_req=1 with the captured addr/wr/wstrb/wdata stable until sram_addr_ok, then go to WAIT.
  - flush in REQ before addr_ok: drop sram_req and go to IDLE.
  - flush in the same cycle as addr_ok: go to CANCEL.
- WAIT:
  - sram_req=0.
  - On sram_data_ok: register the extended rdata, set resp_valid=1, go to DONE.
  - flush in WAIT: go to CANCEL.
  - sram_data_ok arriving in the same cycle as addr_ok is legal; the transition goes directly to DONE.
- CANCEL:
  - Wait for sram_data_ok, discard the data, go to IDLE.
  - stallreq stays 1 throughout CANCEL.
  - No new request is accepted until IDLE.
- DONE:
  - stallreq=0 and resp_valid=1.
  - If pipe_hold=0, go to IDLE next cycle with resp_valid cleared.
  - If pipe_hold=1, stay in DONE and keep resp_rdata stable.
  - flush in DONE: go to IDLE.
- stallreq = 1 in REQ, WAIT and CANCEL, and in IDLE when an aligned req_valid is present. Otherwise 0.
- Load extraction:
  - The lane is selected by captured addr[1:0].
  - byte/half results are sign-extended unless req_unsigned=1.
  - word passes through unchanged.
- A new req_valid is accepted only in IDLE. req_valid in any other state is ignored; the stall holds EX.
- rst mid-operation returns to IDLE immediately. A late sram_data_ok is ignored, and the SRAM is expected to be reset with the same rst.

Test Plan:
- Load word, 0-wait SRAM: LW addr 0x100; addr_ok and data_ok both in the accept cycle, rdata 0xDEADBEEF -> sram_req one cycle, resp_rdata=0xDEADBEEF next cycle, stallreq high exactly 1 cycle.
- Store byte: SB addr 0x203, wdata 0x000000A5 -> sram_wstrb=1000, sram_addr=0x200, sram_wdata=0xA5A5A5A5, sram_wr=1, resp_rdata=0.
- Signed/unsigned half: rdata 0x8001_7FFF; LH @0x2 -> 0xFFFF8001; LHU @0x2 -> 0x00008001; LH @0x0 -> 0x00007FFF.
- Backpressure: addr_ok delayed 3 cycles, data_ok 2 cycles after it -> sram_addr/wdata stable across REQ, stallreq high 6 cycles total, single resp.
- Misaligned: LW @0x102 -> err_adel 1-cycle pulse, no sram_req, stallreq 0; SH @0x1 -> err_ades pulse.
- Flush in WAIT, then pipe_hold: flush asserted during WAIT -> CANCEL, data_ok discarded, resp_valid never set. Separate case: DONE with pipe_hold=1 for 2 cycles -> resp_rdata held, then IDLE.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// rtl/data_mem_access_ctrl.sv - load/store sequencer onto the split-handshake data SRAM port
// Builds byte lanes, stalls the pipe while an access is in flight, returns extended load data.
module data_mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  input  logic              pipe_hold,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [3:0]        sram_wstrb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              stallreq,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              err_adel,
  output logic              err_ades
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t state, next_state;

  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_unsigned;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_wstrb;
  logic [DATA_W-1:0] cap_wdata;

  logic              in_idle, misaligned, accept;
  logic [3:0]        lane_wstrb;
  logic [DATA_W-1:0] lane_wdata;
  logic              cur_we, cur_unsigned;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        cur_wstrb;
  logic [DATA_W-1:0] cur_wdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_ext, load_result;

  assign in_idle = (state == S_IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = |req_addr[1:0];
    endcase
  end

  assign accept = in_idle && req_valid && !flush && !misaligned;

  always_comb begin
    lane_wstrb = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        lane_wstrb = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: lane_wstrb = 4'b1111;
    endcase
    if (!req_we) lane_wstrb = 4'b0000;
  end

  // The accept cycle works straight off the EX inputs; later cycles use the captured copy.
  assign cur_we       = in_idle ? req_we       : cap_we;
  assign cur_size     = in_idle ? req_size     : cap_size;
  assign cur_unsigned = in_idle ? req_unsigned : cap_unsigned;
  assign cur_addr     = in_idle ? req_addr     : cap_addr;
  assign cur_wstrb    = in_idle ? lane_wstrb   : cap_wstrb;
  assign cur_wdata    = in_idle ? lane_wdata   : cap_wdata;

  always_comb begin
    byte_sel = 8'h00;
    case (cur_addr[1:0])
      2'd0: byte_sel = sram_rdata[7:0];
      2'd1: byte_sel = sram_rdata[15:8];
      2'd2: byte_sel = sram_rdata[23:16];
      2'd3: byte_sel = sram_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = cur_addr[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (cur_size)
      2'b00:   load_ext = {{24{byte_sel[7] & ~cur_unsigned}}, byte_sel};
      2'b01:   load_ext = {{16{half_sel[15] & ~cur_unsigned}}, half_sel};
      default: load_ext = sram_rdata;
    endcase
    load_result = cur_we ? '0 : load_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // A flush that lands with or after addr_ok must still drain the data_ok beat.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (sram_addr_ok) next_state = sram_data_ok ? S_DONE : S_WAIT;
          else              next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (sram_addr_ok) begin
          if (flush) next_state = sram_data_ok ? S_IDLE : S_CANCEL;
          else       next_state = sram_data_ok ? S_DONE : S_WAIT;
        end else if (flush) begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush)             next_state = sram_data_ok ? S_IDLE : S_CANCEL;
        else if (sram_data_ok) next_state = S_DONE;
      end
      S_DONE: begin
        if (flush || !pipe_hold) next_state = S_IDLE;
      end
      S_CANCEL: begin
        if (sram_data_ok) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we       <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wstrb    <= 4'b0000;
      cap_wdata    <= '0;
      resp_rdata   <= '0;
    end else begin
      if (accept) begin
        cap_we       <= req_we;
        cap_size     <= req_size;
        cap_unsigned <= req_unsigned;
        cap_addr     <= req_addr;
        cap_wstrb    <= lane_wstrb;
        cap_wdata    <= lane_wdata;
      end
      if (next_state == S_DONE && state != S_DONE) resp_rdata <= load_result;
    end
  end

  always_comb begin
    sram_req   = accept || (state == S_REQ);
    sram_wr    = sram_req && cur_we;
    sram_wstrb = sram_req ? cur_wstrb : 4'b0000;
    sram_addr  = sram_req ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
    sram_wdata = sram_req ? cur_wdata : '0;
    stallreq   = accept || (state == S_REQ) || (state == S_WAIT) || (state == S_CANCEL);
    resp_valid = (state == S_DONE);
    err_adel   = in_idle && req_valid && misaligned && !req_we;
    err_ades   = in_idle && req_valid && misaligned && req_we;
  end

endmodule
